sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STROBE_CYCLES, default 1, number of CLK cycles the WE/OE strobe phase lasts (legal range 1..7).
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-low.
REQ-004 a_req  input  1  port A access request, held high until a_ack.
REQ-005 a_we  input  1  port A access type: 1 write, 0 read.
REQ-006 a_addr  input  18  port A word address.
REQ-007 a_wdata  input  16  port A write data.
REQ-008 a_ack  output  1  port A one-cycle completion pulse.
REQ-009 a_rdata  output  16  port A read data, valid while a_ack=1 and held until the next port A read completes.
REQ-010 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: port B equivalents of REQ-004..REQ-009, same widths and directions.
REQ-011 Ram1Addr  output  18  SRAM address.
REQ-012 Ram1Data  inout  16  SRAM data bus.
REQ-013 Ram1OE, Ram1WE, Ram1EN  output  1 each  SRAM output enable, write enable and chip enable, all active-low.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-016 IDLE: if any req is high, grant one port, latch its we/addr/wdata into internal registers, then go to SETUP; otherwise stay in IDLE.
REQ-017 Arbitration: single requester wins; if both request, the port not granted most recently wins; after reset, A has priority.
REQ-018 SETUP (1 cycle): Ram1EN=0 and Ram1Addr=latched addr. For a write, Ram1Data is driven and Ram1WE=1. For a read, Ram1OE=0.
REQ-019 STROBE (STROBE_CYCLES cycles, counted by a 3-bit counter): for a write, Ram1WE=0 with address and data held stable. For a read, Ram1OE=0.
REQ-020 Read data is captured from Ram1Data on the last STROBE cycle's closing edge.
REQ-021 HOLD (1 cycle): Ram1WE=1. For a write, address and data remain driven. For a read, Ram1OE stays 0. The granted port's ack=1. Next state is IDLE.
REQ-022 Access latency, from the IDLE cycle with req high to the ack cycle: STROBE_CYCLES+2 cycles. Minimum back-to-back period: STROBE_CYCLES+3 cycles.
REQ-023 Ram1Data is high-impedance except during SETUP/STROBE/HOLD of a write.
REQ-024 In IDLE: Ram1EN=1, Ram1OE=1, Ram1WE=1, Ram1Addr holds its last value.
REQ-025 Requests are sampled only in IDLE. Changes on req/we/addr/wdata after grant do not affect the access in flight. Deassertion before ack does not abort the access.
REQ-026 If a requester keeps req high in the IDLE cycle following its ack, that is a new access.
REQ-027 Ram1WE and Ram1OE are never both 0. a_ack and b_ack are never both 1.
REQ-028 A read completion updates only the granted port's rdata. A write completion leaves both rdata registers unchanged.

Reset
REQ-029 RST=0 forces, asynchronously, the following: state=IDLE, Ram1EN=Ram1OE=Ram1WE=1, Ram1Data high-impedance, Ram1Addr=0, acks=0, a_rdata=b_rdata=0, busy=0, last-grant=B (so A has priority next), strobe counter=0.
REQ-030 Reset asserted mid-access abandons the access with no ack. After release, the first arbitration follows REQ-017.

Structure
REQ-031 Shared package sram_arb_pkg holds the FSM state encoding, ADDR_W=18 and DATA_W=16.
REQ-032 The two-way round-robin grant logic is a sub-module rr_grant2 (inputs req_a, req_b, last_grant; output grant_b).

Verification
REQ-033 Port A write: a_addr=0x00010, a_wdata=0xBEEF, STROBE_CYCLES=1 -> SETUP, then 1 cycle of Ram1WE=0 with Ram1Addr=0x00010 and Ram1Data=0xBEEF, then a_ack in the 3rd cycle after the request cycle; Ram1OE=1 throughout.
REQ-034 Port B read of 0x00010 after REQ-033, SRAM model returning 0xBEEF -> b_ack with b_rdata=0xBEEF, a_rdata unchanged, Ram1Data never driven by the DUT.
REQ-035 a_req and b_req held high continuously after reset -> grants alternate A,B,A,B; each ack spaced 4 cycles apart; acks never overlap.
REQ-036 STROBE_CYCLES=3, write 0x1234 to 0x3FFFF -> Ram1WE low for exactly 3 cycles; ack 5 cycles after the request cycle.
REQ-037 RST asserted during a write's STROBE -> same-cycle Ram1WE=1, Ram1EN=1, bus high-impedance, no ack; after release, a pending a_req is granted from IDLE.
REQ-038 Address and data changed on the cycle after grant -> SRAM sees the originally latched values throughout the access.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths and FSM encoding for the two-port SRAM arbiter.
package sram_arb_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;
endpackage

// File: rtl/sram_arbiter_rr_grant2.sv
// Two-way round-robin grant: when both ports request, the one not granted last wins.
module rr_grant2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_b
);
    // last_grant=1 means B was granted most recently, so A wins a tie.
    assign grant_b = req_b & (~req_a | ~last_grant);
endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two request/ack ports onto a single asynchronous SRAM with a
// SETUP / STROBE / HOLD access sequence.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] Ram1Addr,
    inout  logic [DATA_W-1:0] Ram1Data,
    output logic              Ram1OE,
    output logic              Ram1WE,
    output logic              Ram1EN,
    output logic              busy
);
    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q;
    logic                grant_b;
    logic                grant_en;
    logic                last_b_q;
    logic                gnt_b_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                strobe_end;
    logic                active;

    rr_grant2 u_rr (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_b_q),
        .grant_b    (grant_b)
    );

    assign grant_en   = (state_q == IDLE) && (a_req || b_req);
    assign strobe_end = (state_q == STROBE) && (cnt_q == STROBE_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_req || b_req) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_q == STROBE_LAST) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            last_b_q <= 1'b1;
            gnt_b_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == STROBE && !strobe_end) cnt_q <= cnt_q + 3'd1;
            else                                  cnt_q <= 3'd0;
            if (grant_en) begin
                last_b_q <= grant_b;
                gnt_b_q  <= grant_b;
                we_q     <= grant_b ? b_we   : a_we;
                addr_q   <= grant_b ? b_addr : a_addr;
            end
        end
    end

    // Write data only matters while a write is driven, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (grant_en) wdata_q <= grant_b ? b_wdata : a_wdata;
    end

    // Read data is sampled on the closing edge of the last strobe cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (strobe_end && !we_q) begin
            if (gnt_b_q) b_rdata_q <= Ram1Data;
            else         a_rdata_q <= Ram1Data;
        end
    end

    assign active   = (state_q != IDLE);
    assign busy     = active;
    assign Ram1EN   = ~active;
    assign Ram1OE   = ~(active && !we_q);
    assign Ram1WE   = ~((state_q == STROBE) && we_q);
    assign Ram1Addr = addr_q;
    assign Ram1Data = (active && we_q) ? wdata_q : {DATA_W{1'bz}};
    assign a_ack    = (state_q == HOLD) && !gnt_b_q;
    assign b_ack    = (state_q == HOLD) &&  gnt_b_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-strobe instance with an SRAM model,
// plus a STROBE_CYCLES=3 instance for the long-strobe write.
module tb_sram_arbiter;
    logic        CLK;
    logic        RST;
    logic        a_req, a_we, b_req, b_we;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_oe, ram_we, ram_en, busy;

    logic        d3_a_req, d3_a_we;
    logic [17:0] d3_a_addr;
    logic [15:0] d3_a_wdata;
    logic        d3_a_ack, d3_b_ack;
    logic [15:0] d3_a_rdata, d3_b_rdata;
    logic [17:0] d3_ram_addr;
    wire  [15:0] d3_ram_data;
    logic        d3_ram_oe, d3_ram_we, d3_ram_en, d3_busy;

    logic [15:0] mem [0:255];
    int          checks = 0;
    int          errors = 0;
    int          we_low;

    sram_arbiter dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .Ram1Addr(ram_addr), .Ram1Data(ram_data),
        .Ram1OE(ram_oe), .Ram1WE(ram_we), .Ram1EN(ram_en), .busy(busy)
    );

    sram_arbiter #(.STROBE_CYCLES(3)) dut3 (
        .CLK(CLK), .RST(RST),
        .a_req(d3_a_req), .a_we(d3_a_we), .a_addr(d3_a_addr), .a_wdata(d3_a_wdata),
        .a_ack(d3_a_ack), .a_rdata(d3_a_rdata),
        .b_req(1'b0), .b_we(1'b0), .b_addr(18'h0), .b_wdata(16'h0),
        .b_ack(d3_b_ack), .b_rdata(d3_b_rdata),
        .Ram1Addr(d3_ram_addr), .Ram1Data(d3_ram_data),
        .Ram1OE(d3_ram_oe), .Ram1WE(d3_ram_we), .Ram1EN(d3_ram_en), .busy(d3_busy)
    );

    // Weak pull-ups make an undriven bus read as all ones.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (ram_data[i]);
        pullup (d3_ram_data[i]);
    end

    // Asynchronous SRAM model: drives on an enabled read, stores on WE low.
    assign ram_data = (!ram_en && !ram_oe && ram_we) ? mem[ram_addr[7:0]] : 16'hzzzz;

    always @(posedge CLK) begin
        if (!ram_en && !ram_we) mem[ram_addr[7:0]] <= ram_data;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        d3_a_req = 0; d3_a_we = 0; d3_a_addr = '0; d3_a_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 + 16'(i);

        // Reset state
        step();
        chk("rst_en",    32'(ram_en), 32'd1);
        chk("rst_oe",    32'(ram_oe), 32'd1);
        chk("rst_we",    32'(ram_we), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_acks",  {30'd0, a_ack, b_ack}, 32'd0);
        chk("rst_addr",  32'(ram_addr), 32'd0);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
        chk("rst_bus",   32'(ram_data), 32'h0000_FFFF);
        RST = 1'b1;
        step();

        // Port A write 0xBEEF to 0x10, inputs disturbed after grant
        a_req = 1; a_we = 1; a_addr = 18'h00010; a_wdata = 16'hBEEF;
        chk("w_idle_busy", 32'(busy), 32'd0);
        step();
        a_addr = 18'h00055; a_wdata = 16'h1111; a_we = 0;
        chk("w_setup_en",   32'(ram_en), 32'd0);
        chk("w_setup_we",   32'(ram_we), 32'd1);
        chk("w_setup_addr", 32'(ram_addr), 32'h10);
        chk("w_setup_bus",  32'(ram_data), 32'hBEEF);
        chk("w_setup_ack",  32'(a_ack), 32'd0);
        step();
        chk("w_strobe_we",   32'(ram_we), 32'd0);
        chk("w_strobe_oe",   32'(ram_oe), 32'd1);
        chk("w_strobe_addr", 32'(ram_addr), 32'h10);
        chk("w_strobe_bus",  32'(ram_data), 32'hBEEF);
        step();
        chk("w_hold_ack",  {30'd0, a_ack, b_ack}, 32'd2);
        chk("w_hold_we",   32'(ram_we), 32'd1);
        chk("w_hold_bus",  32'(ram_data), 32'hBEEF);
        chk("w_hold_addr", 32'(ram_addr), 32'h10);
        a_req = 0;
        step();
        chk("w_idle_en",   32'(ram_en), 32'd1);
        chk("w_idle_bus",  32'(ram_data), 32'h0000_FFFF);
        chk("w_idle_addr", 32'(ram_addr), 32'h10);
        chk("w_mem",       32'(mem[8'h10]), 32'hBEEF);

        // Port B read of 0x10
        b_req = 1; b_we = 0; b_addr = 18'h00010; b_wdata = 16'h0F0F;
        step();
        chk("r_setup_oe", 32'(ram_oe), 32'd0);
        chk("r_setup_we", 32'(ram_we), 32'd1);
        step();
        chk("r_strobe_oe", 32'(ram_oe), 32'd0);
        chk("r_strobe_we", 32'(ram_we), 32'd1);
        step();
        chk("r_hold_ack",   {30'd0, a_ack, b_ack}, 32'd1);
        chk("r_hold_oe",    32'(ram_oe), 32'd0);
        chk("r_hold_rdata", 32'(b_rdata), 32'hBEEF);
        chk("r_a_rdata",    32'(a_rdata), 32'd0);
        b_req = 0;
        step();
        chk("r_idle_bus", 32'(ram_data), 32'h0000_FFFF);

        // Both ports request reads continuously: alternate A, B, A, B
        a_req = 1; a_we = 0; a_addr = 18'h00021;
        b_req = 1; b_we = 0; b_addr = 18'h00010;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("rr_ack_%0d", k), {30'd0, a_ack, b_ack},
                (k == 3 || k == 11) ? 32'd2 : (k == 7 || k == 15) ? 32'd1 : 32'd0);
            chk($sformatf("rr_weoe_%0d", k), 32'(ram_we | ram_oe), 32'd1);
            if (k == 3) chk("rr_a_rdata", 32'(a_rdata), 32'hC021);
            if (k == 7) chk("rr_b_rdata", 32'(b_rdata), 32'hBEEF);
            if (k == 15) begin a_req = 0; b_req = 0; end
        end
        step();
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Reset during a write strobe; B pending too, but A must win afterwards
        a_req = 1; a_we = 1; a_addr = 18'h00040; a_wdata = 16'hA5A5;
        step();
        step();
        chk("rs_strobe_we", 32'(ram_we), 32'd0);
        b_req = 1; b_we = 0; b_addr = 18'h00010;
        RST = 1'b0;
        #1;
        chk("rs_we",    32'(ram_we), 32'd1);
        chk("rs_en",    32'(ram_en), 32'd1);
        chk("rs_bus",   32'(ram_data), 32'h0000_FFFF);
        chk("rs_ack",   {30'd0, a_ack, b_ack}, 32'd0);
        chk("rs_busy",  32'(busy), 32'd0);
        chk("rs_rdata", {a_rdata, b_rdata}, 32'd0);
        step();
        chk("rs_held_ack", {30'd0, a_ack, b_ack}, 32'd0);
        RST = 1'b1;
        step();
        chk("rs_setup_busy", 32'(busy), 32'd1);
        chk("rs_setup_addr", 32'(ram_addr), 32'h40);
        chk("rs_setup_bus",  32'(ram_data), 32'hA5A5);
        step();
        step();
        chk("rs_hold_ack", {30'd0, a_ack, b_ack}, 32'd2);
        a_req = 0; b_req = 0;
        step();
        chk("rs_mem", 32'(mem[8'h40]), 32'hA5A5);

        // STROBE_CYCLES=3 write of 0x1234 to 0x3FFFF
        d3_a_req = 1; d3_a_we = 1; d3_a_addr = 18'h3FFFF; d3_a_wdata = 16'h1234;
        we_low = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (!d3_ram_we) we_low++;
            chk($sformatf("s3_ack_%0d", k), {30'd0, d3_a_ack, d3_b_ack},
                (k == 5) ? 32'd2 : 32'd0);
            if (k == 3) begin
                chk("s3_addr", 32'(d3_ram_addr), 32'h3FFFF);
                chk("s3_bus",  32'(d3_ram_data), 32'h1234);
                chk("s3_oe",   32'(d3_ram_oe), 32'd1);
                chk("s3_en",   32'(d3_ram_en), 32'd0);
            end
            if (k == 5) d3_a_req = 0;
        end
        chk("s3_we_low", 32'(we_low), 32'd3);
        chk("s3_idle", {30'd0, d3_busy, d3_ram_en}, 32'd1);
        chk("s3_rdata", {d3_a_rdata, d3_b_rdata}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
